// File: rtl/trial_sequencer_if.sv
// Handshake and status bundle between a trial controller and the trial sequencer.
interface trial_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] n_trials;
    logic       reward_en;
    logic [7:0] weight_in;
    logic       pre_spike;
    logic       post_spike;
    logic       reward;
    logic       busy;
    logic       done;
    logic [7:0] trial_cnt;
    logic [8:0] w_delta;

    modport master (
        output start, abort, n_trials, reward_en, weight_in,
        input  pre_spike, post_spike, reward, busy, done, trial_cnt, w_delta
    );

    modport slave (
        input  start, abort, n_trials, reward_en, weight_in,
        output pre_spike, post_spike, reward, busy, done, trial_cnt, w_delta
    );
endinterface

// File: rtl/trial_sequencer.sv
// Runs a block of pre/post spike pairing trials and reports the weight change across the block.
module trial_sequencer #(
    parameter int unsigned GAP     = 1,
    parameter int unsigned RECOVER = 1
) (
    input logic           clk,
    input logic           rst,
    trial_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_GAP, S_POST, S_RECOVER, S_DONE} state_t;

    localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [3:0] REC_LAST = 4'(RECOVER - 1);

    state_t     state;
    logic [7:0] n_lat;
    logic [7:0] w_start;
    logic [3:0] gap_cnt;
    logic [3:0] rec_cnt;
    logic       pre_q, post_q, reward_q, busy_q, done_q;
    logic [7:0] cnt_q;
    logic [8:0] delta_q;

    // Outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            n_lat    <= '0;
            w_start  <= '0;
            gap_cnt  <= '0;
            rec_cnt  <= '0;
            pre_q    <= 1'b0;
            post_q   <= 1'b0;
            reward_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            delta_q  <= '0;
        end else if (bus.abort && state != S_IDLE) begin
            state    <= S_IDLE;
            gap_cnt  <= '0;
            rec_cnt  <= '0;
            pre_q    <= 1'b0;
            post_q   <= 1'b0;
            reward_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pre_q  <= 1'b0;
            post_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort && bus.n_trials != 8'd0) begin
                        state    <= S_PRE;
                        n_lat    <= bus.n_trials;
                        w_start  <= bus.weight_in;
                        cnt_q    <= '0;
                        pre_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        reward_q <= bus.reward_en;
                    end
                end
                S_PRE: begin
                    if (GAP == 0) begin
                        state  <= S_POST;
                        post_q <= 1'b1;
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= S_POST;
                        post_q  <= 1'b1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_POST: begin
                    state   <= S_RECOVER;
                    rec_cnt <= '0;
                end
                S_RECOVER: begin
                    if (rec_cnt == REC_LAST) begin
                        rec_cnt <= '0;
                        cnt_q   <= cnt_q + 8'd1;
                        if (cnt_q == n_lat - 8'd1) begin
                            state    <= S_DONE;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            reward_q <= 1'b0;
                            delta_q  <= {1'b0, bus.weight_in} - {1'b0, w_start};
                        end else begin
                            state <= S_PRE;
                            pre_q <= 1'b1;
                        end
                    end else begin
                        rec_cnt <= rec_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pre_spike  = pre_q;
    assign bus.post_spike = post_q;
    assign bus.reward     = reward_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trial_cnt  = cnt_q;
    assign bus.w_delta    = delta_q;
endmodule

// File: tb/tb_trial_sequencer.sv
// Bench for trial_sequencer: table-driven blocks on a default build plus a GAP=0 build.
module tb_trial_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trial_sequencer_if b0();
    trial_sequencer_if b1();

    trial_sequencer u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    trial_sequencer #(.GAP(0), .RECOVER(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct packed {
        logic       pre;
        logic       post;
        logic       reward;
        logic       busy;
        logic       done;
        logic [7:0] cnt;
    } out_t;

    typedef struct {
        int         n;
        logic       rew;
        logic [7:0] w0;
        logic [7:0] w1;
        int         abort_at;    // 0 = never
        int         restart_at;  // 0 = never
        logic       start_abort; // abort asserted together with start
    } vec_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Independent timeline model for the default build: 4-cycle trials.
    function automatic out_t model(vec_t v, int k, logic [7:0] cnt0);
        out_t o;
        int   pos;
        o = '0;
        if (v.n == 0 || v.start_abort) begin
            o.cnt = cnt0;
            return o;
        end
        if (v.abort_at != 0 && k > v.abort_at) begin
            o.cnt = 8'((v.abort_at - 1) / 4);
            return o;
        end
        if (k <= 4 * v.n) begin
            pos      = (k - 1) % 4;
            o.pre    = (pos == 0);
            o.post   = (pos == 2);
            o.busy   = 1'b1;
            o.reward = v.rew;
            o.cnt    = 8'((k - 1) / 4);
        end else begin
            o.done = (k == 4 * v.n + 1);
            o.cnt  = 8'(v.n);
        end
        return o;
    endfunction

    task automatic step(input int dut, input string name);
        out_t act;
        out_t exp;
        @(posedge clk);
        #1;
        act = (dut == 1) ? {b1.pre_spike, b1.post_spike, b1.reward, b1.busy, b1.done, b1.trial_cnt}
                         : {b0.pre_spike, b0.post_spike, b0.reward, b0.busy, b0.done, b0.trial_cnt};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s @%0t: pre/post/rew/busy/done/cnt got %h expected %h", name, $time, act, exp);
            end
        end
    endtask

    task automatic check_delta(input int dut, input logic [8:0] exp, input string name);
        logic [8:0] act;
        act = (dut == 1) ? b1.w_delta : b0.w_delta;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: w_delta got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] cnt0;
        logic [8:0] delta_exp;
        out_t       z;
        int         kmax;
        logic       completed;

        vecs[0] = '{n: 3,   rew: 1'b0, w0: 8'd0,   w1: 8'd0,   abort_at: 0, restart_at: 0, start_abort: 1'b0};
        vecs[1] = '{n: 3,   rew: 1'b1, w0: 8'd10,  w1: 8'd40,  abort_at: 0, restart_at: 0, start_abort: 1'b0};
        vecs[2] = '{n: 2,   rew: 1'b0, w0: 8'd200, w1: 8'd50,  abort_at: 0, restart_at: 0, start_abort: 1'b0};
        vecs[3] = '{n: 5,   rew: 1'b1, w0: 8'd7,   w1: 8'd99,  abort_at: 6, restart_at: 3, start_abort: 1'b0};
        vecs[4] = '{n: 0,   rew: 1'b1, w0: 8'd1,   w1: 8'd2,   abort_at: 0, restart_at: 0, start_abort: 1'b0};
        vecs[5] = '{n: 2,   rew: 1'b1, w0: 8'd3,   w1: 8'd4,   abort_at: 0, restart_at: 0, start_abort: 1'b1};
        vecs[6] = '{n: 2,   rew: 1'b1, w0: 8'd5,   w1: 8'd6,   abort_at: 8, restart_at: 0, start_abort: 1'b0};
        vecs[7] = '{n: 255, rew: 1'b0, w0: 8'd255, w1: 8'd0,   abort_at: 0, restart_at: 0, start_abort: 1'b0};

        z = '0;
        b0.start = 1'b1; b0.abort = 1'b0; b0.n_trials = 8'd5; b0.reward_en = 1'b1; b0.weight_in = 8'd9;
        b1.start = 1'b0; b1.abort = 1'b0; b1.n_trials = 8'd0; b1.reward_en = 1'b0; b1.weight_in = 8'd0;

        // Reset held with start asserted, then idle
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin exp_q.push_back(z); step(0, "reset_hold"); end
        rst = 1'b0; b0.start = 1'b0;
        for (int i = 0; i < 3; i++) begin exp_q.push_back(z); step(0, "reset_idle"); end
        check_delta(0, 9'h000, "reset_delta");
        cnt0 = 8'd0;
        delta_exp = 9'h000;

        foreach (vecs[vi]) begin
            b0.start     = 1'b1;
            b0.abort     = vecs[vi].start_abort;
            b0.n_trials  = 8'(vecs[vi].n);
            b0.reward_en = vecs[vi].rew;
            b0.weight_in = vecs[vi].w0;
            exp_q.push_back(model(vecs[vi], 1, cnt0));
            step(0, $sformatf("vec%0d_k1", vi));
            b0.start     = 1'b0;
            b0.abort     = 1'b0;
            b0.reward_en = ~vecs[vi].rew;
            b0.weight_in = vecs[vi].w1;
            if (vecs[vi].n == 0 || vecs[vi].start_abort) kmax = 3;
            else if (vecs[vi].abort_at != 0) kmax = vecs[vi].abort_at + 2;
            else kmax = 4 * vecs[vi].n + 2;
            for (int k = 1; k < kmax; k++) begin
                b0.abort    = (k == vecs[vi].abort_at);
                b0.start    = (k == vecs[vi].restart_at);
                b0.n_trials = (k == vecs[vi].restart_at) ? 8'd1 : 8'(vecs[vi].n);
                exp_q.push_back(model(vecs[vi], k + 1, cnt0));
                step(0, $sformatf("vec%0d_k%0d", vi, k + 1));
            end
            b0.abort = 1'b0;
            b0.start = 1'b0;
            completed = (vecs[vi].n != 0) && !vecs[vi].start_abort &&
                        (vecs[vi].abort_at == 0 || vecs[vi].abort_at > 4 * vecs[vi].n);
            if (completed) delta_exp = {1'b0, vecs[vi].w1} - {1'b0, vecs[vi].w0};
            check_delta(0, delta_exp, $sformatf("vec%0d_delta", vi));
            cnt0 = model(vecs[vi], kmax, cnt0).cnt;
        end

        // Reset mid-block cancels with no done pulse
        b0.start = 1'b1; b0.n_trials = 8'd3; b0.reward_en = 1'b1; b0.weight_in = 8'd77;
        exp_q.push_back(model(vecs[1], 1, cnt0));
        step(0, "rstmid_k1");
        b0.start = 1'b0;
        for (int k = 2; k <= 4; k++) begin exp_q.push_back(model(vecs[1], k, cnt0)); step(0, "rstmid_run"); end
        rst = 1'b1;
        exp_q.push_back(z); step(0, "rstmid_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin exp_q.push_back(z); step(0, "rstmid_after"); end
        check_delta(0, 9'h000, "rstmid_delta");

        // GAP=0 build: 3-cycle trial, done at s+4
        b1.start = 1'b1; b1.n_trials = 8'd1; b1.reward_en = 1'b1; b1.weight_in = 8'd20;
        exp_q.push_back('{pre: 1'b1, post: 1'b0, reward: 1'b1, busy: 1'b1, done: 1'b0, cnt: 8'd0});
        step(1, "gap0_s1");
        b1.start = 1'b0; b1.weight_in = 8'd25;
        exp_q.push_back('{pre: 1'b0, post: 1'b1, reward: 1'b1, busy: 1'b1, done: 1'b0, cnt: 8'd0});
        step(1, "gap0_s2");
        exp_q.push_back('{pre: 1'b0, post: 1'b0, reward: 1'b1, busy: 1'b1, done: 1'b0, cnt: 8'd0});
        step(1, "gap0_s3");
        exp_q.push_back('{pre: 1'b0, post: 1'b0, reward: 1'b0, busy: 1'b0, done: 1'b1, cnt: 8'd1});
        step(1, "gap0_s4");
        exp_q.push_back('{pre: 1'b0, post: 1'b0, reward: 1'b0, busy: 1'b0, done: 1'b0, cnt: 8'd1});
        step(1, "gap0_s5");
        check_delta(1, 9'h005, "gap0_delta");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
